// File: rtl/decode_stage_mc.sv
// Multi-lane decode stage: per-lane decoders feeding an in-order decoded queue with issue window.
// Optional interrupt injection on lane 0 is enabled by defining DECODE_IRQ_INJECT_EN.
package decode_stage_mc_pkg;
  typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11} priv_lvl_t;
  typedef logic [31:0] ex_cause_t;

  localparam ex_cause_t BREAKPOINT        = 32'd3;
  localparam ex_cause_t ILLEGAL_INSTR     = 32'd2;
  localparam ex_cause_t ENV_CALL_UMODE    = 32'd8;
  localparam ex_cause_t ENV_CALL_SMODE    = 32'd9;
  localparam ex_cause_t ENV_CALL_MMODE    = 32'd11;
  localparam ex_cause_t INSTR_PAGE_FAULT  = 32'd12;
  localparam ex_cause_t M_TIMER_INTERRUPT = 32'h8000_0007;

  typedef struct packed {
    logic        valid;
    ex_cause_t   cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
    logic        predict;
    exception_t  ex;
  } fetch_entry_t;

  typedef enum logic [2:0] {
    FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR
  } fu_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_MUL, OP_CSR, OP_FENCE, OP_SYS
  } fu_op_t;

  typedef struct packed {
    logic [2:0]  index;
    logic [31:0] pc;
    fu_t         fu;
    fu_op_t      op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [2:0]  lsu_size;
    logic        use_imm;
    logic        use_pc;
    logic        valid;
    logic        predict;
    exception_t  ex;
  } scoreboard_entry_t;
endpackage

module decoder
  import decode_stage_mc_pkg::*;
(
  input  fetch_entry_t      fetch_entry_i,
  input  priv_lvl_t         priv_lvl_i,
  input  logic              debug_mode_i,
  input  logic              tvm_i,
  input  logic              tw_i,
  input  logic              tsr_i,
  output scoreboard_entry_t entry_o
);
  logic [31:0] instr, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        illegal, ecall, ebreak;

  function automatic fu_op_t alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  assign instr  = fetch_entry_i.instruction;
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    entry_o         = '0;
    entry_o.pc      = fetch_entry_i.address;
    entry_o.predict = fetch_entry_i.predict;
    entry_o.rd      = instr[11:7];
    entry_o.rs1     = instr[19:15];
    illegal         = 1'b0;
    ecall           = 1'b0;
    ebreak          = 1'b0;
    case (instr[6:0])
      7'b0110111, 7'b0010111: begin
        entry_o.fu      = FU_ALU;
        entry_o.op      = OP_ADD;
        entry_o.rs1     = '0;
        entry_o.result  = imm_u;
        entry_o.use_imm = 1'b1;
        entry_o.use_pc  = instr[5] == 1'b0;
      end
      7'b1101111: begin
        entry_o.fu     = FU_CTRL_FLOW;
        entry_o.op     = OP_JAL;
        entry_o.rs1    = '0;
        entry_o.result = imm_j;
        entry_o.use_pc = 1'b1;
      end
      7'b1100111: begin
        entry_o.fu     = FU_CTRL_FLOW;
        entry_o.op     = OP_JALR;
        entry_o.result = imm_i;
        illegal        = funct3 != 3'b000;
      end
      7'b1100011: begin
        entry_o.fu     = FU_CTRL_FLOW;
        entry_o.rs2    = instr[24:20];
        entry_o.rd     = '0;
        entry_o.result = imm_b;
        case (funct3)
          3'b000:  entry_o.op = OP_BEQ;
          3'b001:  entry_o.op = OP_BNE;
          3'b100:  entry_o.op = OP_BLT;
          3'b101:  entry_o.op = OP_BGE;
          3'b110:  entry_o.op = OP_BLTU;
          3'b111:  entry_o.op = OP_BGEU;
          default: illegal    = 1'b1;
        endcase
      end
      7'b0000011: begin
        entry_o.fu       = FU_LOAD;
        entry_o.op       = OP_LD;
        entry_o.result   = imm_i;
        entry_o.lsu_size = funct3;
        illegal          = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      7'b0100011: begin
        entry_o.fu       = FU_STORE;
        entry_o.op       = OP_ST;
        entry_o.rs2      = instr[24:20];
        entry_o.rd       = '0;
        entry_o.result   = imm_s;
        entry_o.lsu_size = funct3;
        illegal          = funct3[2] || (funct3 == 3'b011);
      end
      7'b0010011: begin
        entry_o.fu      = FU_ALU;
        entry_o.op      = alu_op(funct3, (funct3 == 3'b101) && instr[30]);
        entry_o.result  = imm_i;
        entry_o.use_imm = 1'b1;
        if (funct3 == 3'b001) illegal = funct7 != 7'b0;
        if (funct3 == 3'b101) illegal = {instr[31], instr[29:25]} != 6'b0;
      end
      7'b0110011: begin
        entry_o.rs2 = instr[24:20];
        if (funct7 == 7'b0000001) begin
          entry_o.fu = FU_MULT;
          entry_o.op = OP_MUL;
        end else if (funct7 == 7'b0 ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          entry_o.fu = FU_ALU;
          entry_o.op = alu_op(funct3, instr[30]);
        end else begin
          illegal = 1'b1;
        end
      end
      7'b0001111: begin
        entry_o.fu  = FU_NONE;
        entry_o.op  = OP_FENCE;
        entry_o.rd  = '0;
        entry_o.rs1 = '0;
      end
      7'b1110011: begin
        entry_o.fu = FU_CSR;
        if (funct3 == 3'b000) begin
          entry_o.op  = OP_SYS;
          entry_o.rd  = '0;
          entry_o.rs1 = '0;
          case (instr[31:20])
            12'h000: ecall   = 1'b1;
            12'h001: ebreak  = 1'b1;
            12'h302: illegal = priv_lvl_i != PRIV_M;
            12'h102: illegal = (priv_lvl_i == PRIV_U) || (priv_lvl_i == PRIV_S && tsr_i);
            12'h105: illegal = tw_i && (priv_lvl_i != PRIV_M);
            12'h7b2: illegal = !debug_mode_i;
            default: illegal = (funct7 != 7'b0001001) ||
                               (priv_lvl_i == PRIV_U) || (priv_lvl_i == PRIV_S && tvm_i);
          endcase
        end else if (funct3 == 3'b100) begin
          illegal = 1'b1;
        end else begin
          entry_o.op      = OP_CSR;
          entry_o.result  = {20'b0, instr[31:20]};
          entry_o.use_imm = funct3[2];
        end
      end
      default: illegal = 1'b1;
    endcase

    // Fetch faults win over anything the instruction bits would have raised.
    if (fetch_entry_i.ex.valid) begin
      entry_o.ex = fetch_entry_i.ex;
    end else if (illegal) begin
      entry_o.ex = '{valid: 1'b1, cause: ILLEGAL_INSTR, tval: 32'b0};
    end else if (ecall) begin
      entry_o.ex.valid = 1'b1;
      case (priv_lvl_i)
        PRIV_U:  entry_o.ex.cause = ENV_CALL_UMODE;
        PRIV_S:  entry_o.ex.cause = ENV_CALL_SMODE;
        default: entry_o.ex.cause = ENV_CALL_MMODE;
      endcase
    end else if (ebreak) begin
      entry_o.ex = '{valid: 1'b1, cause: BREAKPOINT, tval: 32'b0};
    end
    entry_o.valid = entry_o.ex.valid;
  end
endmodule

module decode_stage_mc
  import decode_stage_mc_pkg::*;
#(
  parameter int unsigned NR_LANES = 2,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  priv_lvl_t                        priv_lvl_i,
  input  logic                             debug_mode_i,
  input  logic                             tvm_i,
  input  logic                             tw_i,
  input  logic                             tsr_i,
`ifdef DECODE_IRQ_INJECT_EN
  input  logic                             irq_pending_i,
  input  ex_cause_t                        irq_cause_i,
`endif
  input  logic [NR_LANES-1:0]              fetch_valid_i,
  input  fetch_entry_t [NR_LANES-1:0]      fetch_entry_i,
  output logic                             fetch_ready_o,
  output logic [NR_LANES-1:0]              issue_valid_o,
  output scoreboard_entry_t [NR_LANES-1:0] issue_entry_o,
  input  logic [NR_LANES-1:0]              issue_ack_i
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, push_cnt, pop_cnt;
  logic             fence_q, fence_d;
  logic             push_en, push_run, pop_run, hit_ex;
  logic [NR_LANES-1:0] wr_en;
  logic [PTR_W-1:0]    wr_idx [NR_LANES];
  logic [PTR_W-1:0]    rd_idx [NR_LANES];

  scoreboard_entry_t                queue_q [DEPTH];
  scoreboard_entry_t [NR_LANES-1:0] dec_entry, wr_entry;

  for (genvar k = 0; k < NR_LANES; k++) begin : g_lane
    decoder u_decoder (
      .fetch_entry_i (fetch_entry_i[k]),
      .priv_lvl_i    (priv_lvl_i),
      .debug_mode_i  (debug_mode_i),
      .tvm_i         (tvm_i),
      .tw_i          (tw_i),
      .tsr_i         (tsr_i),
      .entry_o       (dec_entry[k])
    );
  end

  always_comb begin
    wr_entry = dec_entry;
`ifdef DECODE_IRQ_INJECT_EN
    // An injected interrupt turns lane 0 into the fence point for the group.
    if (irq_pending_i && !dec_entry[0].ex.valid) begin
      wr_entry[0].ex    = '{valid: 1'b1, cause: irq_cause_i, tval: 32'b0};
      wr_entry[0].valid = 1'b1;
    end
`endif
    fetch_ready_o = !fence_q && (count_q <= CNT_W'(DEPTH - NR_LANES));
    push_en       = fetch_ready_o && fetch_valid_i[0] && !flush_i;
    push_run      = push_en;
    push_cnt      = '0;
    hit_ex        = 1'b0;
    wr_en         = '0;
    for (int k = 0; k < NR_LANES; k++) begin
      wr_idx[k] = tail_q + PTR_W'(k);
      if (push_run && fetch_valid_i[k]) begin
        wr_en[k] = 1'b1;
        push_cnt = push_cnt + CNT_W'(1);
        if (wr_entry[k].ex.valid) begin
          hit_ex   = 1'b1;
          push_run = 1'b0;
        end
      end else begin
        push_run = 1'b0;
      end
    end
  end

  always_comb begin
    pop_run = 1'b1;
    pop_cnt = '0;
    for (int k = 0; k < NR_LANES; k++) begin
      rd_idx[k]        = head_q + PTR_W'(k);
      issue_valid_o[k] = (count_q > CNT_W'(k)) && !flush_i;
      issue_entry_o[k] = queue_q[rd_idx[k]];
      if (pop_run && issue_valid_o[k] && issue_ack_i[k]) begin
        pop_cnt = pop_cnt + CNT_W'(1);
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  always_comb begin
    if (flush_i) begin
      count_d = '0;
      head_d  = tail_q;
      tail_d  = tail_q;
      fence_d = 1'b0;
    end else begin
      count_d = count_q + push_cnt - pop_cnt;
      head_d  = head_q + PTR_W'(pop_cnt);
      tail_d  = tail_q + PTR_W'(push_cnt);
      fence_d = fence_q | hit_ex;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      fence_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      fence_q <= fence_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_LANES; k++) begin
      if (wr_en[k]) queue_q[wr_idx[k]] <= wr_entry[k];
    end
  end
endmodule

// File: tb/tb_decode_stage_mc.sv
// Directed bench for decode_stage_mc (NR_LANES=2, DEPTH=8); covers DECODE_IRQ_INJECT_EN when defined.
module tb_decode_stage_mc;
  import decode_stage_mc_pkg::*;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD  = 32'h0010_8133;  // add  x2,x1,x1
  localparam logic [31:0] I_ILL  = 32'h0000_0000;

  logic clk, rst_n, flush;
  logic [1:0] fv, ack, iv;
  logic ready;
  fetch_entry_t [1:0] fe;
  scoreboard_entry_t [1:0] ie;
`ifdef DECODE_IRQ_INJECT_EN
  logic irq_pending;
  ex_cause_t irq_cause;
`endif
  int n_tests, n_fail;

  decode_stage_mc #(.NR_LANES(2), .DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .priv_lvl_i(PRIV_M), .debug_mode_i(1'b0), .tvm_i(1'b0), .tw_i(1'b0), .tsr_i(1'b0),
`ifdef DECODE_IRQ_INJECT_EN
    .irq_pending_i(irq_pending), .irq_cause_i(irq_cause),
`endif
    .fetch_valid_i(fv), .fetch_entry_i(fe), .fetch_ready_o(ready),
    .issue_valid_o(iv), .issue_entry_o(ie), .issue_ack_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic fetch_entry_t mk(input logic [31:0] pc, input logic [31:0] ins);
    fetch_entry_t f;
    f = '0;
    f.address = pc;
    f.instruction = ins;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    flush = 1'b1; fv = 2'b00; ack = 2'b00;
    tick();
    flush = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] pc);
    fv = 2'b11; fe[0] = mk(pc, I_ADDI); fe[1] = mk(pc + 32'd4, I_ADD);
    tick();
    fv = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; fv = 2'b00; ack = 2'b00;
    fe[0] = mk(32'h0, I_ADDI); fe[1] = mk(32'h4, I_ADD);
    #2;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL reset_issue_valid: got %b want 00", iv); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear();
    fv = 2'b11; fe[0] = mk(32'h100, I_ADDI); fe[1] = mk(32'h104, I_ADD);
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", ready); end
    tick();
    fv = 2'b00;
    n_tests++; if (iv !== 2'b11) begin n_fail++; $display("FAIL basic_valid: got %b want 11", iv); end
    n_tests++; if (ie[0].fu !== FU_ALU) begin n_fail++; $display("FAIL basic_fu0: got %0d want %0d", ie[0].fu, FU_ALU); end
    n_tests++; if (ie[1].fu !== FU_ALU) begin n_fail++; $display("FAIL basic_fu1: got %0d want %0d", ie[1].fu, FU_ALU); end
    n_tests++; if (ie[0].pc !== 32'h100) begin n_fail++; $display("FAIL basic_pc0: got %h want 100", ie[0].pc); end
    n_tests++; if (ie[0].result !== 32'd5) begin n_fail++; $display("FAIL basic_imm0: got %h want 5", ie[0].result); end
    n_tests++; if (ie[0].rd !== 5'd1) begin n_fail++; $display("FAIL basic_rd0: got %0d want 1", ie[0].rd); end
    n_tests++; if ({ie[1].rs1, ie[1].rs2, ie[1].rd} !== {5'd1, 5'd1, 5'd2}) begin
      n_fail++; $display("FAIL basic_regs1: got %0d/%0d/%0d want 1/1/2", ie[1].rs1, ie[1].rs2, ie[1].rd); end
    n_tests++; if (ie[1].op !== OP_ADD) begin n_fail++; $display("FAIL basic_op1: got %0d want %0d", ie[1].op, OP_ADD); end
    n_tests++; if (ie[0].ex.valid !== 1'b0) begin n_fail++; $display("FAIL basic_ex0: got %b want 0", ie[0].ex.valid); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready2: got %b want 1", ready); end
  endtask

  task automatic test_ready_boundary();
    clear();
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bound_ready_cnt%0d: got %b want 1", 2*i, ready); end
      push_pair(32'h200 + 32'(8*i));
    end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bound_ready_cnt8: got %b want 0", ready); end
    n_tests++; if (ie[0].pc !== 32'h200) begin n_fail++; $display("FAIL bound_head8: got %h want 200", ie[0].pc); end
    ack = 2'b01; fv = 2'b11; fe[0] = mk(32'h900, I_ADDI); fe[1] = mk(32'h904, I_ADD);
    tick();
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bound_ready_cnt7: got %b want 0", ready); end
    n_tests++; if (ie[0].pc !== 32'h204) begin n_fail++; $display("FAIL bound_head7: got %h want 204", ie[0].pc); end
    tick();
    ack = 2'b00; fv = 2'b00;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bound_ready_cnt6: got %b want 1", ready); end
    n_tests++; if ({ie[0].pc, ie[1].pc} !== {32'h208, 32'h20C}) begin
      n_fail++; $display("FAIL bound_head6: got %h/%h want 208/20c", ie[0].pc, ie[1].pc); end
    ack = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    ack = 2'b00;
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL bound_drained: got %b want 00", iv); end
  endtask

  task automatic test_partial_valid();
    clear();
    fv = 2'b10; fe[0] = mk(32'h2F0, I_ADDI); fe[1] = mk(32'h2F4, I_ADD);
    tick();
    fv = 2'b00;
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL partial_10: got %b want 00", iv); end
    fv = 2'b01; fe[0] = mk(32'h300, I_ADDI); fe[1] = mk(32'h304, I_ADD);
    tick();
    fv = 2'b00;
    n_tests++; if (iv !== 2'b01) begin n_fail++; $display("FAIL partial_01: got %b want 01", iv); end
    n_tests++; if (ie[0].pc !== 32'h300) begin n_fail++; $display("FAIL partial_pc: got %h want 300", ie[0].pc); end
    push_pair(32'h308);
    n_tests++; if (ie[1].pc !== 32'h308) begin n_fail++; $display("FAIL partial_next: got %h want 308", ie[1].pc); end
    ack = 2'b10;
    tick();
    n_tests++; if (ie[0].pc !== 32'h300) begin n_fail++; $display("FAIL ackgap_head: got %h want 300", ie[0].pc); end
    ack = 2'b11;
    tick();
    ack = 2'b00;
    n_tests++; if (iv !== 2'b01) begin n_fail++; $display("FAIL ackgap_left: got %b want 01", iv); end
    n_tests++; if (ie[0].pc !== 32'h30C) begin n_fail++; $display("FAIL ackgap_pc: got %h want 30c", ie[0].pc); end
  endtask

  task automatic test_exception_fence();
    clear();
    fv = 2'b11; fe[0] = mk(32'h400, I_ILL); fe[1] = mk(32'h404, I_ADD);
    tick();
    fv = 2'b00;
    n_tests++; if (iv !== 2'b01) begin n_fail++; $display("FAIL fence_valid: got %b want 01", iv); end
    n_tests++; if ({ie[0].ex.valid, ie[0].ex.cause, ie[0].ex.tval} !== {1'b1, ILLEGAL_INSTR, 32'h0}) begin
      n_fail++; $display("FAIL fence_ex: got %b/%h/%h want 1/2/0", ie[0].ex.valid, ie[0].ex.cause, ie[0].ex.tval); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL fence_ready: got %b want 0", ready); end
    ack = 2'b01;
    tick();
    ack = 2'b00; fv = 2'b11; fe[0] = mk(32'h408, I_ADDI);
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL fence_ready_empty: got %b want 0", ready); end
    tick();
    fv = 2'b00;
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL fence_blocked: got %b want 00", iv); end
    clear();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL fence_flush_ready: got %b want 1", ready); end
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL fence_flush_valid: got %b want 00", iv); end
    fv = 2'b11; fe[0] = mk(32'h500, I_ADDI); fe[1] = mk(32'h504, I_ADD);
    fe[1].ex = '{valid: 1'b1, cause: INSTR_PAGE_FAULT, tval: 32'h504};
    tick();
    fv = 2'b00;
    n_tests++; if (iv !== 2'b11) begin n_fail++; $display("FAIL fetchex_valid: got %b want 11", iv); end
    n_tests++; if ({ie[1].ex.cause, ie[1].ex.tval} !== {INSTR_PAGE_FAULT, 32'h504}) begin
      n_fail++; $display("FAIL fetchex_cause: got %h/%h want c/504", ie[1].ex.cause, ie[1].ex.tval); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL fetchex_ready: got %b want 0", ready); end
    clear();
  endtask

  task automatic test_back_to_back_wrap();
    logic [31:0] exp_pc;
    clear();
    exp_pc = 32'h8000_0000;
    for (int i = 0; i < 21; i++) begin
      if (i < 20) begin
        fv = 2'b11;
        fe[0] = mk(32'h8000_0000 + 32'(8*i), I_ADDI);
        fe[1] = mk(32'h8000_0004 + 32'(8*i), I_ADD);
      end else begin
        fv = 2'b00;
      end
      ack = iv;
      n_tests++; if (iv !== ((i == 0) ? 2'b00 : 2'b11)) begin n_fail++; $display("FAIL wrap_valid_c%0d: got %b", i, iv); end
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready_c%0d: got %b want 1", i, ready); end
      for (int k = 0; k < 2; k++) begin
        if (iv[k]) begin
          n_tests++; if (ie[k].pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", ie[k].pc, exp_pc); end
          exp_pc = exp_pc + 32'd4;
        end
      end
      tick();
    end
    fv = 2'b00; ack = 2'b00;
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL wrap_drained: got %b want 00", iv); end
    n_tests++; if (exp_pc !== 32'h8000_00A0) begin n_fail++; $display("FAIL wrap_total: got %h want 800000a0", exp_pc); end
  endtask

  task automatic test_flush();
    clear();
    fv = 2'b11; fe[0] = mk(32'h600, I_ADDI); fe[1] = mk(32'h604, I_ADD); flush = 1'b1;
    tick();
    flush = 1'b0; fv = 2'b00;
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL flushpush_valid: got %b want 00", iv); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL flushpush_ready: got %b want 1", ready); end
    push_pair(32'h610);
    flush = 1'b1; ack = 2'b11;
    #1;
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL flush_mask: got %b want 00", iv); end
    tick();
    flush = 1'b0; ack = 2'b00;
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL flush_empty: got %b want 00", iv); end
    push_pair(32'h620);
    n_tests++; if ({iv, ie[0].pc, ie[1].pc} !== {2'b11, 32'h620, 32'h624}) begin
      n_fail++; $display("FAIL flush_realign: got %b %h/%h want 11 620/624", iv, ie[0].pc, ie[1].pc); end
    clear();
  endtask

  task automatic test_reset_mid();
    push_pair(32'h700);
    n_tests++; if (iv !== 2'b11) begin n_fail++; $display("FAIL rstmid_pre: got %b want 11", iv); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({iv, ready} !== 3'b001) begin n_fail++; $display("FAIL rstmid_async: got %b/%b want 00/1", iv, ready); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_tests++; if (iv !== 2'b00) begin n_fail++; $display("FAIL rstmid_after: got %b want 00", iv); end
  endtask

`ifdef DECODE_IRQ_INJECT_EN
  task automatic test_irq_inject();
    clear();
    irq_pending = 1'b1; irq_cause = M_TIMER_INTERRUPT;
    fv = 2'b11; fe[0] = mk(32'h800, I_ADDI); fe[1] = mk(32'h804, I_ADD);
    tick();
    irq_pending = 1'b0; fv = 2'b00;
    n_tests++; if (iv !== 2'b01) begin n_fail++; $display("FAIL irq_valid: got %b want 01", iv); end
    n_tests++; if ({ie[0].ex.valid, ie[0].ex.cause} !== {1'b1, M_TIMER_INTERRUPT}) begin
      n_fail++; $display("FAIL irq_cause: got %b/%h want 1/80000007", ie[0].ex.valid, ie[0].ex.cause); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL irq_fence: got %b want 0", ready); end
    clear();
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0;
`ifdef DECODE_IRQ_INJECT_EN
    irq_pending = 1'b0; irq_cause = '0;
`endif
    test_reset();
    test_basic();
    test_ready_boundary();
    test_partial_valid();
    test_exception_fence();
    test_back_to_back_wrap();
    test_flush();
    test_reset_mid();
`ifdef DECODE_IRQ_INJECT_EN
    test_irq_inject();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
